// File: rtl/wb_pkg.sv
// Shared definitions for the writeback sink: unit codes, register-file geometry
// and the pending-write FIFO entry layout.
package wb_pkg;

    localparam logic [2:0] FX_UNIT    = 3'd0;
    localparam logic [2:0] LS_UNIT    = 3'd2;

    localparam int GPR_IDX_W  = 5;
    localparam int GPR_W      = 64;
    localparam int CR_W       = 32;
    localparam int CR_FIELD_W = 4;

    typedef struct packed {
        logic                 live;
        logic [GPR_IDX_W-1:0] idx;
        logic [GPR_W-1:0]     data;
    } pending_entry_t;

endpackage

// File: rtl/wb_pending_fifo.sv
// Pending GPR write queue for the second load/store write port: ring of entries
// with live bits, WAW kill on incoming writes and per-read-port hazard flags.
module wb_pending_fifo
    import wb_pkg::*;
#(
    parameter int pendingDepth = 4
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 push,
    input  logic [GPR_IDX_W-1:0] push_idx,
    input  logic [GPR_W-1:0]     push_data,
    input  logic                 pop,
    input  logic                 kill1_en,
    input  logic [GPR_IDX_W-1:0] kill1_idx,
    input  logic                 kill2_en,
    input  logic [GPR_IDX_W-1:0] kill2_idx,
    input  logic [GPR_IDX_W-1:0] rd_addr_a,
    input  logic [GPR_IDX_W-1:0] rd_addr_b,
    output pending_entry_t       head,
    output logic                 empty,
    output logic                 pending_a,
    output logic                 pending_b,
    output logic                 stall,
    output logic                 overflow
);

    localparam int PTR_W = $clog2(pendingDepth);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(pendingDepth);

    pending_entry_t   entries [pendingDepth];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             stall_q;
    logic             overflow_q;

    assign empty  = (count == '0);
    assign full   = (count == DEPTH_C);
    assign do_pop = pop && !empty;
    // A full queue only takes a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head   = entries[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    always_comb begin
        pending_a = 1'b0;
        pending_b = 1'b0;
        for (int i = 0; i < pendingDepth; i++) begin
            if (entries[i].live && entries[i].idx == rd_addr_a) pending_a = 1'b1;
            if (entries[i].live && entries[i].idx == rd_addr_b) pending_b = 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < pendingDepth; i++) begin
                entries[i] <= '0;
            end
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < pendingDepth; i++) begin
                if (entries[i].live &&
                    ((kill1_en && entries[i].idx == kill1_idx) ||
                     (kill2_en && entries[i].idx == kill2_idx))) begin
                    entries[i].live <= 1'b0;
                end
            end
            if (do_pop) begin
                entries[rd_ptr].live <= 1'b0;
                rd_ptr               <= rd_ptr + 1'b1;
            end
            // Written last so a new entry is never hit by this edge's kill.
            if (do_push) begin
                entries[wr_ptr] <= '{live: 1'b1, idx: push_idx, data: push_data};
                wr_ptr          <= wr_ptr + 1'b1;
            end
            count   <= count_next;
            stall_q <= (count_next >= DEPTH_C - 1'b1);
            if (push && !do_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign stall    = stall_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/regfile_writeback_sink.sv
// Writeback bus sink: GPR file, condition register and single-port write arbitration.
// Define WB_BYPASS_EN to forward this cycle's port write and CR update to the read outputs.
module regfile_writeback_sink
    import wb_pkg::*;
#(
    parameter int         regWidth     = 5,
    parameter int         dataWidth    = 64,
    parameter int         pendingDepth = 4,
    parameter logic [2:0] FXUnitCode   = FX_UNIT,
    parameter logic [2:0] LdStUnitCode = LS_UNIT
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [2:0]           functionalUnitCode_i,
    input  logic                 reg1WritebackEnable_i,
    input  logic                 reg2WritebackEnable_i,
    input  logic [5:0]           reg1WritebackAddress_i,
    input  logic [5:0]           reg2WritebackAddress_i,
    input  logic [dataWidth-1:0] reg1WritebackVal_i,
    input  logic [dataWidth-1:0] reg2WritebackVal_i,
    input  logic [regWidth-1:0]  rdAddrA_i,
    input  logic [regWidth-1:0]  rdAddrB_i,
    output logic [dataWidth-1:0] rdDataA_o,
    output logic [dataWidth-1:0] rdDataB_o,
    output logic                 rdPendingA_o,
    output logic                 rdPendingB_o,
    output logic [CR_W-1:0]      crVal_o,
    output logic                 stall_o,
    output logic                 overflow_o
);

    localparam int NUM_GPR = 1 << regWidth;

    logic [dataWidth-1:0] gpr [NUM_GPR];
    logic [CR_W-1:0]      cr;
    logic [CR_W-1:0]      cr_next;

    logic                 unit_fx;
    logic                 unit_ls;
    logic                 w1_ok;
    logic                 fx_cr;
    logic                 ls_w2;
    logic [regWidth-1:0]  idx1;
    logic [regWidth-1:0]  idx2;

    logic                 port_en;
    logic [regWidth-1:0]  port_idx;
    logic [dataWidth-1:0] port_data;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_empty;
    pending_entry_t       fifo_head;

    assign unit_fx = (functionalUnitCode_i == FXUnitCode);
    assign unit_ls = (functionalUnitCode_i == LdStUnitCode);
    assign idx1    = reg1WritebackAddress_i[regWidth-1:0];
    assign idx2    = reg2WritebackAddress_i[regWidth-1:0];

    // Address MSB set marks a non-GPR target; such writes are dropped outright.
    assign w1_ok = reg1WritebackEnable_i && !reg1WritebackAddress_i[5] && (unit_fx || unit_ls);
    assign fx_cr = unit_fx && reg2WritebackEnable_i && !reg2WritebackAddress_i[5];
    assign ls_w2 = unit_ls && reg2WritebackEnable_i && !reg2WritebackAddress_i[5] &&
                   !(w1_ok && idx2 == idx1);

    always_comb begin
        port_en   = 1'b0;
        port_idx  = idx1;
        port_data = reg1WritebackVal_i;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (w1_ok) begin
            port_en   = 1'b1;
            fifo_push = ls_w2;
        end else if (ls_w2 && fifo_empty) begin
            port_en   = 1'b1;
            port_idx  = idx2;
            port_data = reg2WritebackVal_i;
        end else begin
            // Port is free of incoming data: retire the head, skipping killed entries.
            fifo_push = ls_w2;
            fifo_pop  = !fifo_empty;
            port_en   = !fifo_empty && fifo_head.live;
            port_idx  = fifo_head.idx;
            port_data = fifo_head.data;
        end
    end

    always_comb begin
        cr_next = cr;
        if (fx_cr) begin
            cr_next[int'(reg2WritebackAddress_i[2:0]) * CR_FIELD_W +: CR_FIELD_W] =
                reg2WritebackVal_i[CR_FIELD_W-1:0];
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr[i] <= '0;
            end
            cr <= '0;
        end else begin
            if (port_en) begin
                gpr[port_idx] <= port_data;
            end
            cr <= cr_next;
        end
    end

    wb_pending_fifo #(
        .pendingDepth(pendingDepth)
    ) u_pending (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .push      (fifo_push),
        .push_idx  (idx2),
        .push_data (reg2WritebackVal_i),
        .pop       (fifo_pop),
        .kill1_en  (w1_ok),
        .kill1_idx (idx1),
        .kill2_en  (ls_w2),
        .kill2_idx (idx2),
        .rd_addr_a (rdAddrA_i),
        .rd_addr_b (rdAddrB_i),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .pending_a (rdPendingA_o),
        .pending_b (rdPendingB_o),
        .stall     (stall_o),
        .overflow  (overflow_o)
    );

`ifdef WB_BYPASS_EN
    always_comb begin
        rdDataA_o = (port_en && port_idx == rdAddrA_i) ? port_data : gpr[rdAddrA_i];
        rdDataB_o = (port_en && port_idx == rdAddrB_i) ? port_data : gpr[rdAddrB_i];
        crVal_o   = cr_next;
    end
`else
    always_comb begin
        rdDataA_o = gpr[rdAddrA_i];
        rdDataB_o = gpr[rdAddrB_i];
        crVal_o   = cr;
    end
`endif

endmodule

// File: tb/tb_regfile_writeback_sink.sv
// Vector-table bench for regfile_writeback_sink with a one-cycle scoreboard queue.
module tb_regfile_writeback_sink;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [2:0]  unit;
    logic        e1, e2;
    logic [5:0]  a1, a2;
    logic [63:0] v1, v2;
    logic [4:0]  ra, rb;
    logic [63:0] rdA, rdB;
    logic        pendA, pendB;
    logic [31:0] crv;
    logic        stall, ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock_i = ~clock_i;

    regfile_writeback_sink dut (
        .clock_i                (clock_i),
        .reset_i                (reset_i),
        .functionalUnitCode_i   (unit),
        .reg1WritebackEnable_i  (e1),
        .reg2WritebackEnable_i  (e2),
        .reg1WritebackAddress_i (a1),
        .reg2WritebackAddress_i (a2),
        .reg1WritebackVal_i     (v1),
        .reg2WritebackVal_i     (v2),
        .rdAddrA_i              (ra),
        .rdAddrB_i              (rb),
        .rdDataA_o              (rdA),
        .rdDataB_o              (rdB),
        .rdPendingA_o           (pendA),
        .rdPendingB_o           (pendB),
        .crVal_o                (crv),
        .stall_o                (stall),
        .overflow_o             (ovf)
    );

    typedef struct packed {
        logic [2:0]  unit;
        logic        e1, e2;
        logic [5:0]  a1, a2;
        logic [63:0] v1, v2;
        logic [4:0]  ra, rb;
        logic [63:0] xa;
        logic        xp;
        logic [31:0] xc;
        logic        xs, xo;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];
    vec_t sb [$];

    function automatic vec_t mk(logic [2:0] u, logic we1, logic we2, logic [5:0] wa1, logic [5:0] wa2,
                                logic [63:0] wv1, logic [63:0] wv2, logic [4:0] ca, logic [4:0] cb,
                                logic [63:0] xa, logic xp, logic [31:0] xc, logic xs, logic xo);
        vec_t r;
        r.unit = u; r.e1 = we1; r.e2 = we2; r.a1 = wa1; r.a2 = wa2; r.v1 = wv1; r.v2 = wv2;
        r.ra = ca; r.rb = cb; r.xa = xa; r.xp = xp; r.xc = xc; r.xs = xs; r.xo = xo;
        return r;
    endfunction

    task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, id, act, exp);
        end
    endtask

    task automatic drive_idle();
        unit = 3'd0; e1 = 1'b0; e2 = 1'b0; a1 = '0; a2 = '0; v1 = '0; v2 = '0;
    endtask

    task automatic apply(input vec_t v, input int id);
        vec_t e;
        @(negedge clock_i);
        unit = v.unit; e1 = v.e1; e2 = v.e2; a1 = v.a1; a2 = v.a2; v1 = v.v1; v2 = v.v2;
        ra = v.ra; rb = v.rb;
        sb.push_back(v);
        @(posedge clock_i);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty (step %0d): got 0 entries, expected 1", id);
        end else begin
            e = sb.pop_front();
            chk("rdDataA", id, rdA, e.xa);
            chk("rdPendingB", id, {63'd0, pendB}, {63'd0, e.xp});
            chk("crVal", id, {32'd0, crv}, {32'd0, e.xc});
            chk("stall", id, {63'd0, stall}, {63'd0, e.xs});
            chk("overflow", id, {63'd0, ovf}, {63'd0, e.xo});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        localparam logic [31:0] CR1 = 32'h0000_0A00;
        localparam logic [31:0] CR2 = 32'h5000_0A00;
        localparam logic [2:0]  FX = 3'd0;
        localparam logic [2:0]  LS = 3'd2;

        vecs[0]  = mk(FX, 0, 0, 6'd0, 6'd0, 64'h0, 64'h0, 5'd3, 5'd6, 64'h0, 0, 32'h0, 0, 0);
        vecs[1]  = mk(FX, 1, 1, 6'd3, 6'd2, 64'hDEAD_BEEF, 64'hA, 5'd3, 5'd6, 64'hDEAD_BEEF, 0, CR1, 0, 0);
        vecs[2]  = mk(LS, 1, 1, 6'd5, 6'd6, 64'h11, 64'h22, 5'd5, 5'd6, 64'h11, 1, CR1, 0, 0);
        vecs[3]  = mk(FX, 0, 0, 6'd0, 6'd0, 64'h0, 64'h0, 5'd6, 5'd6, 64'h22, 0, CR1, 0, 0);
        vecs[4]  = mk(LS, 1, 1, 6'd7, 6'd6, 64'h77, 64'h33, 5'd7, 5'd6, 64'h77, 1, CR1, 0, 0);
        vecs[5]  = mk(FX, 1, 0, 6'd6, 6'd0, 64'h99, 64'h0, 5'd6, 5'd6, 64'h99, 0, CR1, 0, 0);
        vecs[6]  = mk(FX, 0, 0, 6'd0, 6'd0, 64'h0, 64'h0, 5'd6, 5'd6, 64'h99, 0, CR1, 0, 0);
        vecs[7]  = mk(LS, 0, 1, 6'd0, 6'd9, 64'h0, 64'h909, 5'd9, 5'd9, 64'h909, 0, CR1, 0, 0);
        vecs[8]  = mk(LS, 1, 1, 6'd10, 6'd10, 64'hA1, 64'hA2, 5'd10, 5'd10, 64'hA1, 0, CR1, 0, 0);
        vecs[9]  = mk(FX, 1, 1, 6'b100011, 6'b100001, 64'hBAD, 64'hF, 5'd3, 5'd3, 64'hDEAD_BEEF, 0, CR1, 0, 0);
        vecs[10] = mk(3'd3, 1, 1, 6'd3, 6'd1, 64'hBAD, 64'hF, 5'd3, 5'd1, 64'hDEAD_BEEF, 0, CR1, 0, 0);
        vecs[11] = mk(FX, 0, 1, 6'd0, 6'd7, 64'h0, 64'h5, 5'd3, 5'd3, 64'hDEAD_BEEF, 0, CR2, 0, 0);
        vecs[12] = mk(LS, 1, 1, 6'd11, 6'd12, 64'hB1, 64'hC2, 5'd11, 5'd12, 64'hB1, 1, CR2, 0, 0);
        vecs[13] = mk(LS, 0, 1, 6'd0, 6'd13, 64'h0, 64'hD3, 5'd12, 5'd13, 64'hC2, 1, CR2, 0, 0);
        vecs[14] = mk(FX, 0, 0, 6'd0, 6'd0, 64'h0, 64'h0, 5'd13, 5'd13, 64'hD3, 0, CR2, 0, 0);
        for (int k = 0; k < 5; k++) begin
            vecs[15+k] = mk(LS, 1, 1, 6'(16+k), 6'(24+k), 64'(256+k), 64'(512+k),
                            5'(16+k), 5'(24+k), 64'(256+k), (k < 4), CR2, (k >= 2), (k == 4));
        end
        for (int j = 0; j < 3; j++) begin
            vecs[20+j] = mk(FX, 0, 0, 6'd0, 6'd0, 64'h0, 64'h0, 5'(24+j), 5'(24+j),
                            64'(512+j), 0, CR2, (j == 0), 1);
        end

        drive_idle();
        ra = 5'd3; rb = 5'd6;
        reset_i = 1'b1;
        #3;
        chk("reset_rdDataA", -1, rdA, 64'h0);
        chk("reset_stall", -1, {63'd0, stall}, 64'h0);
        @(negedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i], i);
        end

        // Two more dual writes leave three entries queued, then reset mid-cycle.
        apply(mk(LS, 1, 1, 6'd29, 6'd30, 64'h129, 64'h230, 5'd29, 5'd30, 64'h129, 1, CR2, 0, 1), 100);
        apply(mk(LS, 1, 1, 6'd31, 6'd21, 64'h131, 64'h221, 5'd31, 5'd21, 64'h131, 1, CR2, 1, 1), 101);
        @(negedge clock_i);
        drive_idle();
        ra = 5'd31; rb = 5'd21;
        #2 reset_i = 1'b1;
        #1;
        chk("async_reset_rdDataA", 102, rdA, 64'h0);
        chk("async_reset_pendingB", 102, {63'd0, pendB}, 64'h0);
        chk("async_reset_stall", 102, {63'd0, stall}, 64'h0);
        chk("async_reset_overflow", 102, {63'd0, ovf}, 64'h0);
        chk("async_reset_cr", 102, {32'd0, crv}, 64'h0);
        @(negedge clock_i);
        reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(mk(FX, 0, 0, 6'd0, 6'd0, 64'h0, 64'h0, 5'(27 + i), 5'd30, 64'h0, 0, 32'h0, 0, 0), 110 + i);
        end

`ifdef WB_BYPASS_EN
        @(negedge clock_i);
        unit = FX; e1 = 1'b1; a1 = 6'd3; v1 = 64'hCAFE; ra = 5'd3;
        #1;
        chk("bypass_same_cycle", 120, rdA, 64'hCAFE);
        @(negedge clock_i);
        drive_idle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
